// File: rtl/usb_bag_pkg.sv
// Shared bag codes, state encoding and pending-bit layout for the usb bag scheduler.
// Response mapping lives here so the priority encoder and any future users agree on it.
package usb_bag_pkg;

  localparam int unsigned BTYPE_W = 4;
  localparam int unsigned PEND_W  = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned ERR_W   = 8;

  typedef logic [BTYPE_W-1:0] btype_t;

  localparam btype_t BAG_INIT   = 4'h0;
  localparam btype_t BAG_DIDX   = 4'h5;
  localparam btype_t BAG_DPARAM = 4'h6;
  localparam btype_t BAG_DDIDX  = 4'h7;
  localparam btype_t BAG_DLINK  = 4'h8;
  localparam btype_t BAG_DTYPE  = 4'h9;
  localparam btype_t BAG_DTEMP  = 4'hA;
  localparam btype_t BAG_DHEAD  = 4'hC;
  localparam btype_t BAG_DATA0  = 4'hD;
  localparam btype_t BAG_DATA1  = 4'hE;

  // pend[3:0] = {LINK, TYPE, TEMP, DATA}
  localparam int unsigned P_DATA = 0;
  localparam int unsigned P_TEMP = 1;
  localparam int unsigned P_TYPE = 2;
  localparam int unsigned P_LINK = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RGAP,
    ST_DECODE,
    ST_PICK,
    ST_WAIT,
    ST_SEND,
    ST_REST
  } state_t;

  function automatic btype_t resp_map(input logic [IDX_W-1:0] idx);
    case (idx)
      IDX_W'(P_LINK): resp_map = BAG_DIDX;
      IDX_W'(P_TYPE): resp_map = BAG_DPARAM;
      IDX_W'(P_TEMP): resp_map = BAG_DDIDX;
      default:        resp_map = BAG_DHEAD;
    endcase
  endfunction

  // LINK/TYPE responses use the short turnaround, TEMP/DATA the long one
  function automatic logic is_ctrl(input logic [IDX_W-1:0] idx);
    is_ctrl = (idx == IDX_W'(P_LINK)) || (idx == IDX_W'(P_TYPE));
  endfunction

endpackage

// File: rtl/usb_bag_prio.sv
// Fixed-priority pick of the next pending response (LINK > TYPE > TEMP > DATA)
// together with the bag type to transmit and its turnaround class.
module usb_bag_prio
  import usb_bag_pkg::*;
(
  input  logic [PEND_W-1:0]  pend,
  output logic               hit_c,
  output logic [IDX_W-1:0]   idx_c,
  output logic [BTYPE_W-1:0] btype_c,
  output logic               ctrl_c
);

  always_comb begin
    hit_c = |pend;
    idx_c = IDX_W'(P_DATA);
    if (pend[P_LINK])      idx_c = IDX_W'(P_LINK);
    else if (pend[P_TYPE]) idx_c = IDX_W'(P_TYPE);
    else if (pend[P_TEMP]) idx_c = IDX_W'(P_TEMP);
    btype_c = resp_map(idx_c);
    ctrl_c  = is_ctrl(idx_c);
  end

endmodule

// File: rtl/usb_bag_sched.sv
// Command/response scheduler between the usb core and board logic: acks received bags,
// queues responses, drives the send handshake with turnaround gaps, and emits periodic data.
module usb_bag_sched
  import usb_bag_pkg::*;
#(
  parameter int unsigned CNUM = 32'h0030,
  parameter int unsigned DNUM = 32'h0050,
  parameter int unsigned WNUM = 32'd6250
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               fs_read,
  input  logic [BTYPE_W-1:0] read_btype,
  output logic               fd_read,
  output logic               fs_send,
  output logic [BTYPE_W-1:0] send_btype,
  input  logic               fd_send,
  input  logic               data_req,
  output logic               link,
  output logic               busy,
  output logic [ERR_W-1:0]   err_cnt
);

  localparam logic [CNT_W-1:0] CLAST = CNT_W'(CNUM - 1);
  localparam logic [CNT_W-1:0] DLAST = CNT_W'(DNUM - 1);
  localparam logic [CNT_W-1:0] WLAST = CNT_W'(WNUM - 1);

  state_t             state;
  logic [PEND_W-1:0]  pend;
  logic [BTYPE_W-1:0] rx_btype;
  logic               cur_ctrl;
  logic [CNT_W-1:0]   cnt;

  logic               hit_c;
  logic [IDX_W-1:0]   idx_c;
  logic [BTYPE_W-1:0] btype_c;
  logic               ctrl_c;
  logic [CNT_W-1:0]   wait_last_c;

  usb_bag_prio u_prio (
    .pend    (pend),
    .hit_c   (hit_c),
    .idx_c   (idx_c),
    .btype_c (btype_c),
    .ctrl_c  (ctrl_c)
  );

  assign wait_last_c = cur_ctrl ? CLAST : DLAST;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pend       <= '0;
      rx_btype   <= BAG_INIT;
      cur_ctrl   <= 1'b0;
      cnt        <= '0;
      fd_read    <= 1'b0;
      fs_send    <= 1'b0;
      send_btype <= BAG_INIT;
      link       <= 1'b0;
      busy       <= 1'b0;
      err_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fs_read) begin
            state    <= ST_RGAP;
            rx_btype <= read_btype;
            fd_read  <= 1'b1;
            busy     <= 1'b1;
          end else if (hit_c) begin
            state <= ST_PICK;
            busy  <= 1'b1;
          end else if (link) begin
            state <= ST_REST;
          end
        end
        // a read interrupts the idle period but keeps the elapsed count
        ST_REST: begin
          if (fs_read) begin
            state    <= ST_RGAP;
            rx_btype <= read_btype;
            fd_read  <= 1'b1;
            busy     <= 1'b1;
          end else if (cnt == WLAST) begin
            pend[P_DATA] <= 1'b1;
            cnt          <= '0;
            state        <= ST_PICK;
            busy         <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_RGAP: begin
          if (!fs_read) begin
            fd_read <= 1'b0;
            state   <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          case (rx_btype)
            BAG_DLINK: begin
              link         <= 1'b1;
              pend[P_LINK] <= 1'b1;
            end
            BAG_DTYPE:            pend[P_TYPE] <= 1'b1;
            BAG_DTEMP:            pend[P_TEMP] <= 1'b1;
            BAG_DATA0, BAG_DATA1: pend[P_DATA] <= 1'b1;
            BAG_INIT: begin
              link <= 1'b0;
              pend <= '0;
            end
            default: if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
          endcase
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        ST_PICK: begin
          if (hit_c) begin
            cur_ctrl    <= ctrl_c;
            send_btype  <= btype_c;
            pend[idx_c] <= 1'b0;
            cnt         <= '0;
            state       <= ST_WAIT;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (cnt == wait_last_c) begin
            fs_send <= 1'b1;
            state   <= ST_SEND;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_SEND: begin
          if (fd_send) begin
            fs_send <= 1'b0;
            cnt     <= '0;
            state   <= ST_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
      // a board request in the same cycle as a clear of the DATA bit wins
      if (data_req) pend[P_DATA] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_usb_bag_sched.sv
// Directed plus randomized bench for usb_bag_sched with a transaction-level reference model
// of the pending set, link flag, error count and response timing.
module tb_usb_bag_sched;

  localparam int CNUM = 48;
  localparam int DNUM = 80;
  localparam int WNUM = 6250;

  localparam logic [3:0] B_INIT   = 4'h0;
  localparam logic [3:0] B_DIDX   = 4'h5;
  localparam logic [3:0] B_DPARAM = 4'h6;
  localparam logic [3:0] B_DDIDX  = 4'h7;
  localparam logic [3:0] B_DLINK  = 4'h8;
  localparam logic [3:0] B_DTYPE  = 4'h9;
  localparam logic [3:0] B_DTEMP  = 4'hA;
  localparam logic [3:0] B_DHEAD  = 4'hC;
  localparam logic [3:0] B_DATA0  = 4'hD;
  localparam logic [3:0] B_DATA1  = 4'hE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fs_read = 1'b0;
  logic [3:0] read_btype = 4'h0;
  logic       fd_read;
  logic       fs_send;
  logic [3:0] send_btype;
  logic       fd_send = 1'b0;
  logic       data_req = 1'b0;
  logic       link;
  logic       busy;
  logic [7:0] err_cnt;

  int errs = 0;
  int checks = 0;
  int t = 0;

  // reference model: pend bits {LINK,TYPE,TEMP,DATA}
  bit       m_link = 1'b0;
  int       m_err = 0;
  bit [3:0] m_pend = 4'b0;

  usb_bag_sched dut (
    .clk        (clk),
    .rst        (rst),
    .fs_read    (fs_read),
    .read_btype (read_btype),
    .fd_read    (fd_read),
    .fs_send    (fs_send),
    .send_btype (send_btype),
    .fd_send    (fd_send),
    .data_req   (data_req),
    .link       (link),
    .busy       (busy),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_bag(input logic [3:0] code, input bit dreq);
    case (code)
      B_DLINK: begin
        m_link    = 1'b1;
        m_pend[3] = 1'b1;
      end
      B_DTYPE:          m_pend[2] = 1'b1;
      B_DTEMP:          m_pend[1] = 1'b1;
      B_DATA0, B_DATA1: m_pend[0] = 1'b1;
      B_INIT: begin
        m_link = 1'b0;
        m_pend = 4'b0;
      end
      default: if (m_err < 255) m_err++;
    endcase
    if (dreq) m_pend[0] = 1'b1;
  endfunction

  // core side of a receive: raise fs_read, hold it, drop it after the ack; optional data_req in DECODE
  task automatic do_read(input logic [3:0] code, input int hold, input bit dreq, output int t_ref);
    fs_read    = 1'b1;
    read_btype = code;
    tick();
    chk("fd_read_rise", {31'b0, fd_read}, 1);
    for (int i = 1; i < hold; i++) begin
      tick();
      chk("fd_read_hold", {31'b0, fd_read}, 1);
    end
    fs_read    = 1'b0;
    read_btype = 4'($urandom);
    tick();
    chk("fd_read_fall", {30'b0, fd_read, busy}, 32'b01);
    t_ref = t;
    if (dreq) begin
      data_req = 1'b1;
      tick();
      data_req = 1'b0;
    end
    model_bag(code, dreq);
  endtask

  task automatic expect_one(input string tag, inout int t_ref, input int gap, input logic [3:0] bt);
    int n = 0;
    int d;
    while (fs_send !== 1'b1 && n < gap + 20) begin
      tick();
      n++;
    end
    chk({tag, "_rise"}, {31'b0, fs_send}, 1);
    if (fs_send !== 1'b1) return;
    chk({tag, "_gap"}, t - t_ref, gap);
    chk({tag, "_btype"}, {28'b0, send_btype}, {28'b0, bt});
    d = $urandom_range(0, 3);
    repeat (d) tick();
    chk({tag, "_hold"}, {27'b0, fs_send, send_btype}, {27'b0, 1'b1, bt});
    fd_send = 1'b1;
    tick();
    fd_send = 1'b0;
    chk({tag, "_drop"}, {30'b0, fs_send, busy}, 0);
    t_ref = t;
  endtask

  // expected responses in priority order; first gap counted from the ack fall
  task automatic drain(input string tag, inout int t_ref);
    bit first = 1'b1;
    while (m_pend != 4'b0) begin
      int idx = 0;
      int n;
      logic [3:0] bt;
      for (int i = 0; i < 4; i++) if (m_pend[i]) idx = i;
      m_pend[idx] = 1'b0;
      n  = (idx >= 2) ? CNUM : DNUM;
      bt = (idx == 3) ? B_DIDX : (idx == 2) ? B_DPARAM : (idx == 1) ? B_DDIDX : B_DHEAD;
      expect_one(tag, t_ref, n + (first ? 3 : 2), bt);
      first = 1'b0;
    end
  endtask

  task automatic quiet(input string tag, input int cycles);
    int hi = 0;
    repeat (cycles) begin
      tick();
      if (fs_send !== 1'b0) hi++;
    end
    chk(tag, hi, 0);
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_link"}, {31'b0, link}, {31'b0, m_link});
    chk({tag, "_err"}, {24'b0, err_cnt}, m_err);
  endtask

  initial begin
    int tr;
    logic [3:0] codes [8];
    codes = '{B_DLINK, B_DTYPE, B_DTEMP, B_DATA0, B_DATA1, B_INIT, 4'h3, 4'hF};

    repeat (3) tick();
    chk("reset_outputs", {13'b0, fd_read, fs_send, send_btype, link, busy, err_cnt}, 0);
    rst = 1'b0;
    quiet("idle100_nosend", 100);
    chk("idle100_state", {29'b0, link, busy, fd_read}, 0);

    // TYPE bag with a board request landing in DECODE
    do_read(B_DTYPE, 1, 1'b1, tr);
    drain("type_then_data", tr);
    check_state("type_then_data");

    // unknown bag: counted, nothing sent
    do_read(4'h3, 1, 1'b0, tr);
    quiet("bad_nosend", 20);
    check_state("bad_one");

    // LINK held three cycles by the core
    do_read(B_DLINK, 3, 1'b0, tr);
    drain("link_resp", tr);
    check_state("linked");

    // autonomous data while linked and idle
    expect_one("auto0", tr, WNUM + DNUM + 2, B_DHEAD);
    expect_one("auto1", tr, WNUM + DNUM + 2, B_DHEAD);

    // read arriving mid-REST is serviced first, period restarts after its send
    repeat (1000) tick();
    do_read(B_DTYPE, 1, 1'b0, tr);
    drain("mid_rest", tr);
    expect_one("auto2", tr, WNUM + DNUM + 2, B_DHEAD);

    // INIT while linked with a same-cycle data request: request survives the clear
    do_read(B_INIT, 2, 1'b1, tr);
    drain("init_dreq", tr);
    check_state("init_dreq");

    // relink, leave a request pending in REST, then INIT clears it
    do_read(B_DLINK, 1, 1'b0, tr);
    drain("relink", tr);
    repeat (2) tick();
    data_req = 1'b1;
    tick();
    data_req = 1'b0;
    m_pend[0] = 1'b1;
    tick();
    do_read(B_INIT, 1, 1'b0, tr);
    quiet("init_clears_pend", 150);
    check_state("init_clear");

    // randomized bag stream against the model
    for (int it = 0; it < 40; it++) begin
      logic [3:0] code;
      code = codes[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) code = 4'($urandom);
      do_read(code, $urandom_range(1, 3), 1'($urandom_range(0, 1)), tr);
      if (m_pend == 4'b0) quiet("rand_nosend", 20);
      else drain("rand", tr);
      check_state("rand");
    end

    // unlink, then push the error count into saturation
    do_read(B_INIT, 1, 1'b0, tr);
    quiet("pre_sat", 5);
    for (int i = 0; i < 300; i++) begin
      do_read((i % 2 == 0) ? 4'h3 : 4'hB, 1, 1'b0, tr);
      tick();
    end
    check_state("err_sat");
    chk("err_sat_value", {24'b0, err_cnt}, 32'hFF);

    // reset asserted while a send is in flight
    do_read(B_DTEMP, 1, 1'b0, tr);
    begin
      int n = 0;
      while (fs_send !== 1'b1 && n < DNUM + 20) begin
        tick();
        n++;
      end
    end
    chk("pre_reset_send", {31'b0, fs_send}, 1);
    rst = 1'b1;
    #1;
    chk("async_reset_outputs", {13'b0, fd_read, fs_send, send_btype, link, busy, err_cnt}, 0);
    tick();
    rst = 1'b0;
    m_link = 1'b0;
    m_err  = 0;
    m_pend = 4'b0;
    quiet("post_reset_quiet", 120);
    check_state("post_reset");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
